// File: rtl/rriot_bus_if.sv
// rriot_bus_if: CPU-side bus interface of the RRIOT.
// Synchronises the asynchronous 6502 bus into clk, decodes each access to
// RAM, I/O or timer, issues one single-cycle strobe per bus cycle and
// returns read data to the CPU until phi2 falls.
module rriot_bus_if #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       phi2,
   input  logic       cs,
   input  logic       rs,
   input  logic       rw,
   input  logic [9:0] addr,
   input  logic [7:0] d_in,
   output logic [7:0] d_out,
   output logic       d_oe,
   output logic       irq_n,
   output logic       ram_en,
   output logic       ram_we,
   output logic [5:0] ram_addr,
   output logic [7:0] ram_wdata,
   input  logic [7:0] ram_rdata,
   output logic       io_en,
   output logic       io_we,
   output logic [1:0] io_a,
   output logic [7:0] io_di,
   input  logic [7:0] io_do,
   output logic       timer_en,
   output logic       timer_we_n,
   output logic [2:0] timer_a,
   output logic [7:0] timer_di,
   input  logic [7:0] timer_do,
   input  logic       timer_irq
);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RD_STROBE = 3'd1,
      ST_RD_CAPT   = 3'd2,
      ST_RD_HOLD   = 3'd3,
      ST_WR_WAIT   = 3'd4,
      ST_WR_STROBE = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      TGT_RAM = 2'd0,
      TGT_IO  = 2'd1,
      TGT_TMR = 2'd2
   } tgt_t;

   // Cycles after reset until the phi2 chain holds real pin samples again.
   localparam logic [2:0] SETTLE_LAST = 3'(SYNC_STAGES + 1);

   // RS selects RAM; otherwise addr[2] splits I/O from timer.
   function automatic tgt_t decode_tgt(input logic rs_v, input logic a2_v);
      tgt_t t;
      if (rs_v) begin
         t = TGT_RAM;
      end else if (a2_v) begin
         t = TGT_TMR;
      end else begin
         t = TGT_IO;
      end
      return t;
   endfunction

   logic [SYNC_STAGES-1:0] phi2_sync_q, cs_sync_q, rs_sync_q, rw_sync_q;
   logic       phi2_dly_q, armed_q;
   logic [2:0] settle_q;
   logic       phi2_s, cs_s, rs_s, rw_s, settled_s, rise_s, fall_s;
   logic       unused_addr_s;

   state_t     state_q, state_d;
   tgt_t       tgt_q, tgt_d, issue_tgt_s;
   logic       issue_s, issue_we_s;

   logic       ram_en_q, ram_en_d, ram_we_q, ram_we_d;
   logic       io_en_q, io_en_d, io_we_q, io_we_d;
   logic       timer_en_q, timer_en_d, timer_we_n_q, timer_we_n_d;
   logic [5:0] ram_addr_q, ram_addr_d;
   logic [1:0] io_a_q, io_a_d;
   logic [2:0] timer_a_q, timer_a_d;
   logic [7:0] ram_wdata_q, ram_wdata_d, io_di_q, io_di_d, timer_di_q, timer_di_d;
   logic [7:0] d_out_q, d_out_d;
   logic       d_oe_q, d_oe_d, irq_n_q;

   assign phi2_s    = phi2_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign rs_s      = rs_sync_q[SYNC_STAGES-1];
   assign rw_s      = rw_sync_q[SYNC_STAGES-1];
   assign settled_s = (settle_q == SETTLE_LAST);
   // A rise only counts once phi2 has been seen low after reset.
   assign rise_s    = phi2_s & ~phi2_dly_q & armed_q;
   assign fall_s    = ~phi2_s & phi2_dly_q;
   // Upper address bits are decoded outside this block.
   assign unused_addr_s = ^addr[9:6];

   // Synchronise the bus control pins into the clk domain.
   always_ff @(posedge clk) begin
      if (rst) begin
         phi2_sync_q <= '0;
         cs_sync_q   <= '0;
         rs_sync_q   <= '0;
         rw_sync_q   <= '0;
      end else begin
         phi2_sync_q <= {phi2_sync_q[SYNC_STAGES-2:0], phi2};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         rs_sync_q   <= {rs_sync_q[SYNC_STAGES-2:0], rs};
         rw_sync_q   <= {rw_sync_q[SYNC_STAGES-2:0], rw};
      end
   end

   // Edge-detect delay and post-reset arming so a phi2 held high across reset is not a rise.
   always_ff @(posedge clk) begin
      if (rst) begin
         phi2_dly_q <= 1'b0;
         settle_q   <= 3'd0;
         armed_q    <= 1'b0;
      end else begin
         phi2_dly_q <= phi2_s;
         if (!settled_s) begin
            settle_q <= settle_q + 3'd1;
         end
         if (settled_s && !phi2_s) begin
            armed_q <= 1'b1;
         end
      end
   end

   // Bus-cycle FSM: next state, latched target/address, captured data.
   always_comb begin
      state_d     = state_q;
      tgt_d       = tgt_q;
      ram_addr_d  = ram_addr_q;
      io_a_d      = io_a_q;
      timer_a_d   = timer_a_q;
      ram_wdata_d = ram_wdata_q;
      io_di_d     = io_di_q;
      timer_di_d  = timer_di_q;
      d_out_d     = d_out_q;
      d_oe_d      = d_oe_q;
      issue_s     = 1'b0;
      issue_we_s  = 1'b0;
      issue_tgt_s = tgt_q;
      case (state_q)
         ST_IDLE: begin
            if (rise_s && cs_s) begin
               tgt_d      = decode_tgt(rs_s, addr[2]);
               ram_addr_d = addr[5:0];
               io_a_d     = addr[1:0];
               timer_a_d  = {addr[3], addr[1:0]};
               if (rw_s) begin
                  state_d     = ST_RD_STROBE;
                  issue_s     = 1'b1;
                  issue_tgt_s = tgt_d;
               end else begin
                  state_d = ST_WR_WAIT;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RD_STROBE: begin
            if (fall_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_CAPT;
            end
         end
         ST_RD_CAPT: begin
            if (fall_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RD_HOLD;
               d_oe_d  = 1'b1;
               case (tgt_q)
                  TGT_RAM: d_out_d = ram_rdata;
                  TGT_IO:  d_out_d = io_do;
                  TGT_TMR: d_out_d = timer_do;
                  default: d_out_d = 8'h00;
               endcase
            end
         end
         ST_RD_HOLD: begin
            if (fall_s) begin
               state_d = ST_IDLE;
               d_oe_d  = 1'b0;
            end else begin
               state_d = ST_RD_HOLD;
            end
         end
         ST_WR_WAIT: begin
            if (fall_s) begin
               state_d    = ST_WR_STROBE;
               issue_s    = 1'b1;
               issue_we_s = 1'b1;
               case (tgt_q)
                  TGT_RAM: ram_wdata_d = d_in;
                  TGT_IO:  io_di_d     = d_in;
                  TGT_TMR: timer_di_d  = d_in;
                  default: ram_wdata_d = ram_wdata_q;
               endcase
            end else begin
               state_d = ST_WR_WAIT;
            end
         end
         ST_WR_STROBE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            d_oe_d  = 1'b0;
         end
      endcase
   end

   // Route the one-cycle strobe and write qualifier to the selected target only.
   always_comb begin
      ram_en_d     = 1'b0;
      ram_we_d     = 1'b0;
      io_en_d      = 1'b0;
      io_we_d      = 1'b0;
      timer_en_d   = 1'b0;
      timer_we_n_d = 1'b1;
      if (issue_s) begin
         case (issue_tgt_s)
            TGT_RAM: begin
               ram_en_d = 1'b1;
               ram_we_d = issue_we_s;
            end
            TGT_IO: begin
               io_en_d = 1'b1;
               io_we_d = issue_we_s;
            end
            TGT_TMR: begin
               timer_en_d   = 1'b1;
               timer_we_n_d = ~issue_we_s;
            end
            default: ram_en_d = 1'b0;
         endcase
      end else begin
         ram_en_d = 1'b0;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tgt_q        <= TGT_RAM;
         ram_en_q     <= 1'b0;
         ram_we_q     <= 1'b0;
         io_en_q      <= 1'b0;
         io_we_q      <= 1'b0;
         timer_en_q   <= 1'b0;
         timer_we_n_q <= 1'b1;
         ram_addr_q   <= 6'd0;
         io_a_q       <= 2'd0;
         timer_a_q    <= 3'd0;
         ram_wdata_q  <= 8'h00;
         io_di_q      <= 8'h00;
         timer_di_q   <= 8'h00;
         d_out_q      <= 8'h00;
         d_oe_q       <= 1'b0;
         irq_n_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         tgt_q        <= tgt_d;
         ram_en_q     <= ram_en_d;
         ram_we_q     <= ram_we_d;
         io_en_q      <= io_en_d;
         io_we_q      <= io_we_d;
         timer_en_q   <= timer_en_d;
         timer_we_n_q <= timer_we_n_d;
         ram_addr_q   <= ram_addr_d;
         io_a_q       <= io_a_d;
         timer_a_q    <= timer_a_d;
         ram_wdata_q  <= ram_wdata_d;
         io_di_q      <= io_di_d;
         timer_di_q   <= timer_di_d;
         d_out_q      <= d_out_d;
         d_oe_q       <= d_oe_d;
         irq_n_q      <= timer_irq;
      end
   end

   assign ram_en     = ram_en_q;
   assign ram_we     = ram_we_q;
   assign ram_addr   = ram_addr_q;
   assign ram_wdata  = ram_wdata_q;
   assign io_en      = io_en_q;
   assign io_we      = io_we_q;
   assign io_a       = io_a_q;
   assign io_di      = io_di_q;
   assign timer_en   = timer_en_q;
   assign timer_we_n = timer_we_n_q;
   assign timer_a    = timer_a_q;
   assign timer_di   = timer_di_q;
   assign d_out      = d_out_q;
   assign d_oe       = d_oe_q;
   assign irq_n      = irq_n_q;

endmodule

// File: tb/tb_rriot_bus_if.sv
// Self-checking bench for rriot_bus_if: directed vector table, hand-written
// reset/irq sequences and randomized bus cycles against a reference model.
module tb_rriot_bus_if;

   localparam int SYNC = 2;
   // Negedge samples from a phi2 pin edge to the cycle after the FSM sees it.
   localparam int LAT  = SYNC + 1;

   typedef struct {
      bit         cs;
      bit         rs;
      bit         rw;
      logic [9:0] addr;
      logic [7:0] wd;
      int         hi;
      int         exp_tgt;   // 0 none, 1 RAM, 2 I/O, 3 timer
      logic [7:0] exp_a;
      logic [7:0] exp_rd;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, phi2, cs, rs, rw, timer_irq;
   logic [9:0] addr;
   logic [7:0] d_in, d_out, ram_wdata, ram_rdata, io_di, io_do, timer_di, timer_do;
   logic       d_oe, irq_n, ram_en, ram_we, io_en, io_we, timer_en, timer_we_n;
   logic [5:0] ram_addr;
   logic [1:0] io_a;
   logic [2:0] timer_a;

   int         total = 0;
   int         bad   = 0;
   logic [7:0] mem     [64];
   logic [7:0] ref_mem [64];
   logic [7:0] io_val, tmr_val;
   bit         mem_ready = 1'b0;
   vec_t       tbl [10];

   always #5 clk = ~clk;

   rriot_bus_if #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .rst(rst), .phi2(phi2), .cs(cs), .rs(rs), .rw(rw),
      .addr(addr), .d_in(d_in), .d_out(d_out), .d_oe(d_oe), .irq_n(irq_n),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .io_en(io_en), .io_we(io_we), .io_a(io_a), .io_di(io_di), .io_do(io_do),
      .timer_en(timer_en), .timer_we_n(timer_we_n), .timer_a(timer_a),
      .timer_di(timer_di), .timer_do(timer_do), .timer_irq(timer_irq)
   );

   // Target-side models: read data valid only in the cycle after the strobe.
   always @(posedge clk) begin
      ram_rdata <= 8'hEE;
      io_do     <= 8'hEE;
      timer_do  <= 8'hEE;
      if (!mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'(i * 37 + 5);
         mem_ready <= 1'b1;
      end else if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata    <= mem[ram_addr];
      end
      if (io_en && !io_we)       io_do    <= io_val ^ {6'd0, io_a};
      if (timer_en && timer_we_n) timer_do <= tmr_val ^ {5'd0, timer_a};
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference: what a bus cycle should do, from the decode rules alone.
   function automatic vec_t predict(input bit c, input bit r, input bit w,
                                    input logic [9:0] a, input logic [7:0] wd, input int hi);
      vec_t v;
      v.cs = c; v.rs = r; v.rw = w; v.addr = a; v.wd = wd; v.hi = hi;
      v.exp_tgt = 0; v.exp_a = 8'h00; v.exp_rd = 8'h00;
      if (c) begin
         if (r) begin
            v.exp_tgt = 1; v.exp_a = {2'b00, a[5:0]}; v.exp_rd = ref_mem[a[5:0]];
         end else if (!a[2]) begin
            v.exp_tgt = 2; v.exp_a = {6'd0, a[1:0]}; v.exp_rd = io_val ^ {6'd0, a[1:0]};
         end else begin
            v.exp_tgt = 3; v.exp_a = {5'd0, a[3], a[1:0]};
            v.exp_rd = tmr_val ^ {5'd0, a[3], a[1:0]};
         end
      end
      return v;
   endfunction

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ctl"}, {ram_en, ram_we, io_en, io_we, timer_en, timer_we_n, d_oe, irq_n},
          8'b0000_0101);
      chk({tag, "_data"}, {ram_addr, ram_wdata, io_a, io_di, timer_a},
          27'd0);
      chk({tag, "_dout"}, {timer_di, d_out}, 16'h0000);
   endtask

   // Run one bus cycle with phi2 high for v.hi samples and low for lo samples.
   task automatic run_cycle(input vec_t v, input int lo);
      int s_cnt = 0, s_idx = -1, s_tgt = 0, s_we = 0, multi = 0;
      int oe_first = -1, oe_last = -1;
      logic [7:0] s_a = 8'h00, s_wd = 8'h00, oe_dout = 8'h00;
      @(negedge clk);
      cs = v.cs; rs = v.rs; rw = v.rw; addr = v.addr; d_in = v.wd;
      repeat (2) @(negedge clk);
      phi2 = 1'b1;
      for (int k = 1; k <= v.hi + lo; k++) begin
         @(negedge clk);
         if ((int'(ram_en) + int'(io_en) + int'(timer_en)) > 1) multi++;
         if (ram_en) begin
            s_cnt++; s_idx = k; s_tgt = 1; s_we = int'(ram_we);
            s_a = {2'b00, ram_addr}; s_wd = ram_wdata;
         end else if (io_en) begin
            s_cnt++; s_idx = k; s_tgt = 2; s_we = int'(io_we);
            s_a = {6'd0, io_a}; s_wd = io_di;
         end else if (timer_en) begin
            s_cnt++; s_idx = k; s_tgt = 3; s_we = int'(!timer_we_n);
            s_a = {5'd0, timer_a}; s_wd = timer_di;
         end
         if (d_oe) begin
            if (oe_first < 0) begin
               oe_first = k;
               oe_dout  = d_out;
            end
            oe_last = k;
         end
         if (k == v.hi) phi2 = 1'b0;
      end
      chk("multi_strobe", multi, 0);
      chk("strobe_count", s_cnt, (v.exp_tgt != 0) ? 1 : 0);
      if (v.exp_tgt != 0) begin
         chk("strobe_target", s_tgt, v.exp_tgt);
         chk("strobe_cycle", s_idx, v.rw ? LAT : v.hi + LAT);
         chk("write_qual", s_we, v.rw ? 0 : 1);
         chk("target_addr", s_a, v.exp_a);
         if (!v.rw) chk("write_data", s_wd, v.wd);
      end
      if (v.exp_tgt != 0 && v.rw && v.hi >= 3) begin
         chk("oe_first", oe_first, LAT + 2);
         chk("oe_last", oe_last, v.hi + LAT - 1);
         chk("read_data", oe_dout, v.exp_rd);
      end else begin
         chk("oe_never", oe_first, -1);
      end
      if (v.cs && v.rs && !v.rw) ref_mem[v.addr[5:0]] = v.wd;
      cs = 1'b0;
   endtask

   initial begin
      int cnt;
      rst = 1'b1; phi2 = 1'b0; cs = 1'b0; rs = 1'b0; rw = 1'b1;
      addr = 10'd0; d_in = 8'h00; timer_irq = 1'b1;
      io_val = 8'h81; tmr_val = 8'h3C;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);

      tbl[0] = '{cs:1, rs:0, rw:0, addr:10'h005, wd:8'h10, hi:5, exp_tgt:3, exp_a:8'h01, exp_rd:8'h00};
      tbl[1] = '{cs:1, rs:0, rw:1, addr:10'h004, wd:8'h00, hi:5, exp_tgt:3, exp_a:8'h00, exp_rd:8'h3C};
      tbl[2] = '{cs:1, rs:1, rw:0, addr:10'h02A, wd:8'h5A, hi:5, exp_tgt:1, exp_a:8'h2A, exp_rd:8'h00};
      tbl[3] = '{cs:1, rs:1, rw:1, addr:10'h02A, wd:8'h00, hi:5, exp_tgt:1, exp_a:8'h2A, exp_rd:8'h5A};
      tbl[4] = '{cs:1, rs:0, rw:1, addr:10'h002, wd:8'h00, hi:6, exp_tgt:2, exp_a:8'h02, exp_rd:8'h83};
      tbl[5] = '{cs:0, rs:0, rw:1, addr:10'h002, wd:8'h00, hi:6, exp_tgt:0, exp_a:8'h00, exp_rd:8'h00};
      tbl[6] = '{cs:1, rs:0, rw:0, addr:10'h001, wd:8'h77, hi:4, exp_tgt:2, exp_a:8'h01, exp_rd:8'h00};
      tbl[7] = '{cs:1, rs:0, rw:0, addr:10'h00F, wd:8'hC3, hi:4, exp_tgt:3, exp_a:8'h07, exp_rd:8'h00};
      tbl[8] = '{cs:1, rs:0, rw:1, addr:10'h004, wd:8'h00, hi:2, exp_tgt:3, exp_a:8'h00, exp_rd:8'h3C};
      tbl[9] = '{cs:1, rs:1, rw:1, addr:10'h13F, wd:8'h00, hi:3, exp_tgt:1, exp_a:8'h3F, exp_rd:8'h20};

      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;
      repeat (8) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         run_cycle(tbl[i], 6);
         if (tbl[i].cs && tbl[i].rs && !tbl[i].rw) chk("ram_model", mem[tbl[i].addr[5:0]], tbl[i].wd);
      end

      // irq_n is a one-clock-delayed copy of timer_irq.
      @(negedge clk);
      timer_irq = 1'b0;
      chk("irq_not_yet", irq_n, 1'b1);
      @(negedge clk);
      chk("irq_fall", irq_n, 1'b0);
      timer_irq = 1'b1;
      @(negedge clk);
      chk("irq_rise", irq_n, 1'b1);

      // Reset while a write waits for phi2 to fall: nothing may be written.
      @(negedge clk);
      cs = 1'b1; rs = 1'b0; rw = 1'b0; addr = 10'h005; d_in = 8'hA5;
      repeat (2) @(negedge clk);
      phi2 = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      cnt = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (ram_en || io_en || timer_en) cnt++;
         if (k == 4) phi2 = 1'b0;
      end
      chk("rst_no_strobe", cnt, 0);
      cs = 1'b0;
      repeat (6) @(negedge clk);
      run_cycle(tbl[0], 6);

      // Randomized bus cycles against the reference model.
      for (int n = 0; n < 40; n++) begin
         vec_t rv;
         io_val  = 8'($urandom);
         tmr_val = 8'($urandom);
         rv = predict($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom),
                      10'($urandom) & 10'h3CF, 8'($urandom), $urandom_range(2, 8));
         run_cycle(rv, $urandom_range(6, 9));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
